button_event_rx: RTL and testbench

- Input-side counterpart to the RGB LED output path on the iCE40UP5K board.
- Conditions one raw pushbutton pin: synchronise, debounce, and turn it into clean level, edge and long-press events.
- Keeps a press counter that LED/status logic can use to select colours or modes.
- Sits directly behind the input pad; outputs are in the clk domain.

---
 rtl/button_event_rx.sv | 175 +++++++++++++++++
 tb/tb_button_event_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_rx.sv
// button_event_rx
//
// Conditions one raw pushbutton pad input into clean clk-domain events.
// The pin is synchronised through two flops, debounced by requiring a run of
// DEBOUNCE_CYCLES consecutive disagreeing samples, and then tracked by a small
// FSM that produces press/release strobes, a one-shot long-press strobe and a
// long-held level. A wrapping press counter is provided for mode/colour select.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   btn_pin       raw asynchronous pad input
//   count_clr     synchronous clear of press_count (wins over a coincident press)
//   btn_level     debounced level, 1 = pressed
//   press_pulse   one-cycle strobe during the first cycle btn_level reads 1
//   release_pulse one-cycle strobe during the first cycle btn_level reads 0
//   long_pulse    one-cycle strobe LONG_CYCLES cycles after press_pulse
//   long_held     high from long_pulse until the accepted release
//   press_count   accepted presses, modulo 2^CNT_W

module button_event_rx #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_pin,
    input  logic             count_clr,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             long_held,
    output logic [CNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic              IDLE_PIN  = 1'(ACTIVE_LOW);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        LONG
    } state_t;

    logic              sync1;
    logic              sync2;
    logic              act;
    logic [DB_W-1:0]   db_cnt;
    logic              accept;
    logic              press_evt;
    logic              release_evt;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              long_pulse_nxt;
    logic              long_held_nxt;

    // The synchroniser idles at the inactive pin level, so a button already
    // held through reset still has to be debounced as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= btn_pin;
            sync2 <= sync1;
        end
    end

    assign act = sync2 ^ IDLE_PIN;

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive cycle
    // of disagreement; any agreeing sample restarts the run.
    assign accept      = (act != btn_level) && (db_cnt == DB_LAST);
    assign press_evt   = accept && !btn_level;
    assign release_evt = accept && btn_level;

    // Debounce counter and the debounced level plus its edge strobes, which
    // are registered together so each strobe lines up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            if (act == btn_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt    <= '0;
                btn_level <= ~btn_level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Hold-tracking FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
            long_held  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            long_pulse <= long_pulse_nxt;
            long_held  <= long_held_nxt;
        end
    end

    // Next-state logic. hold_cnt starts at 0 on the press edge, so reaching
    // LONG_CYCLES-1 puts long_pulse exactly LONG_CYCLES cycles after
    // press_pulse. In LONG the counter is frozen, so only one long_pulse
    // can fire per press.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        long_pulse_nxt = 1'b0;
        long_held_nxt  = long_held;
        case (state)
            RELEASED: begin
                if (press_evt) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (release_evt) begin
                    state_nxt = RELEASED;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt      = LONG;
                    long_pulse_nxt = 1'b1;
                    long_held_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (release_evt) begin
                    state_nxt     = RELEASED;
                    long_held_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = RELEASED;
                long_held_nxt = 1'b0;
            end
        endcase
    end

    // Press counter; a clear in the same cycle as press_pulse discards that press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_count <= '0;
        end else if (count_clr) begin
            press_count <= '0;
        end else if (press_pulse) begin
            press_count <= press_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_button_event_rx.sv
// tb_button_event_rx
//
// Directed bench for button_event_rx with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// ACTIVE_LOW=1, CNT_W=8. Inputs change 1 ns after a rising edge ("edge 0");
// outputs are sampled 1 ns after each following edge, so edge k is the k-th
// rising edge after the input change.

module tb_button_event_rx;

    localparam int DB   = 4;
    localparam int LG   = 20;
    localparam int CW   = 8;
    localparam int LAT  = 2 + DB;

    logic          clk;
    logic          rst_n;
    logic          btn_pin;
    logic          count_clr;
    logic          btn_level;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic          long_held;
    logic [CW-1:0] press_count;

    int total;
    int bad;

    button_event_rx #(
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG),
        .CNT_W           (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_pin       (btn_pin),
        .count_clr     (count_clr),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_held     (long_held),
        .press_count   (press_count)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-derived expectation.
    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive the pin and clear inputs.
    task automatic applyStimulus(input logic pin, input logic clr);
        btn_pin   = pin;
        count_clr = clr;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full clean press and release, ending with the button released.
    task automatic cleanPress();
        applyStimulus(1'b0, 1'b0);
        repeat (8) tick();
        applyStimulus(1'b1, 1'b0);
        repeat (8) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0);

        // Reset state.
        repeat (3) tick();
        checkOutput("rst_level",   int'(btn_level),     0);
        checkOutput("rst_press",   int'(press_pulse),   0);
        checkOutput("rst_release", int'(release_pulse), 0);
        checkOutput("rst_long",    int'(long_pulse),    0);
        checkOutput("rst_held",    int'(long_held),     0);
        checkOutput("rst_count",   int'(press_count),   0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Bounce rejection: 2-cycle low/high runs never reach 4 stable cycles.
        for (int k = 0; k < 30; k++) begin
            applyStimulus(((k / 2) % 2) != 0, 1'b0);
            tick();
            checkOutput("bounce_level", int'(btn_level),   0);
            checkOutput("bounce_press", int'(press_pulse), 0);
            checkOutput("bounce_count", int'(press_count), 0);
        end
        applyStimulus(1'b1, 1'b0);
        repeat (8) tick();
        checkOutput("bounce_end_level", int'(btn_level),   0);
        checkOutput("bounce_end_count", int'(press_count), 0);

        // Clean press held 40 cycles: press at edge 6, long at edge 26.
        applyStimulus(1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            checkOutput("long_level",   int'(btn_level),     int'(k >= LAT));
            checkOutput("long_press",   int'(press_pulse),   int'(k == LAT));
            checkOutput("long_lpulse",  int'(long_pulse),    int'(k == LAT + LG));
            checkOutput("long_held",    int'(long_held),     int'(k >= LAT + LG));
            checkOutput("long_release", int'(release_pulse), 0);
            checkOutput("long_count",   int'(press_count),   int'(k > LAT));
        end
        // Release after the long hold: release strobe and long_held drop at edge 6.
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput("lrel_level",   int'(btn_level),     int'(k < LAT));
            checkOutput("lrel_release", int'(release_pulse), int'(k == LAT));
            checkOutput("lrel_held",    int'(long_held),     int'(k < LAT));
            checkOutput("lrel_lpulse",  int'(long_pulse),    0);
            checkOutput("lrel_press",   int'(press_pulse),   0);
        end

        // Short press: low for 10 cycles, release accepted at edge 16.
        applyStimulus(1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) applyStimulus(1'b1, 1'b0);
            tick();
            checkOutput("short_press",   int'(press_pulse),   int'(k == LAT));
            checkOutput("short_release", int'(release_pulse), int'(k == 10 + LAT));
            checkOutput("short_level",   int'(btn_level),     int'(k >= LAT && k < 10 + LAT));
            checkOutput("short_lpulse",  int'(long_pulse),    0);
            checkOutput("short_held",    int'(long_held),     0);
            checkOutput("short_count",   int'(press_count),   (k > LAT) ? 2 : 1);
        end

        // Plain clear, then 256 presses wrap the counter back to 0.
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("clr_count", int'(press_count), 0);
        for (int n = 1; n <= 256; n++) begin
            cleanPress();
            if (n == 1 || n == 255 || n == 256)
                checkOutput("wrap_count", int'(press_count), n % 256);
        end

        // Clear coinciding with press_pulse wins: result 0, not 1.
        applyStimulus(1'b0, 1'b0);
        repeat (LAT) tick();
        checkOutput("coin_press", int'(press_pulse), 1);
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("coin_count", int'(press_count), 0);
        tick();
        checkOutput("coin_count_hold", int'(press_count), 0);

        // Hold into LONG, then assert reset mid-hold.
        repeat (LG + 2) tick();
        checkOutput("pre_rst_held", int'(long_held), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_level",   int'(btn_level),     0);
        checkOutput("mid_rst_held",    int'(long_held),     0);
        checkOutput("mid_rst_release", int'(release_pulse), 0);
        checkOutput("mid_rst_count",   int'(press_count),   0);
        repeat (2) tick();
        rst_n = 1'b1;
        // Pin still low: a fresh press appears at edge 6, never a release.
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput("post_rst_press",   int'(press_pulse),   int'(k == LAT));
            checkOutput("post_rst_level",   int'(btn_level),     int'(k >= LAT));
            checkOutput("post_rst_release", int'(release_pulse), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
